// File: rtl/cw_output_if.sv
// ---------------------------------------------------------------------------
// cw_output_if
// Bundles the request/grant/data signals between the clockwise output stage
// and its two requesters (CW input stage, PE injection stage), the global
// phase bit, and the outgoing CW link (cwso/cwro/cwdo).
//
//   slave  : view taken by cw_output (requests/data/phase/cwro in,
//            grants/cwso/cwdo out)
//   master : view taken by whatever drives the stage (requesters + link sink)
// ---------------------------------------------------------------------------
interface cw_output_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  polarity;
  logic                  request_cw_even;
  logic                  request_cw_odd;
  logic                  request_pe_even;
  logic                  request_pe_odd;
  logic [DATA_WIDTH-1:0] data_cw_even;
  logic [DATA_WIDTH-1:0] data_cw_odd;
  logic [DATA_WIDTH-1:0] data_pe_even;
  logic [DATA_WIDTH-1:0] data_pe_odd;
  logic                  grant_cw_even;
  logic                  grant_cw_odd;
  logic                  grant_pe_even;
  logic                  grant_pe_odd;
  logic                  cwso;
  logic                  cwro;
  logic [DATA_WIDTH-1:0] cwdo;

  modport slave (
    input  polarity,
    input  request_cw_even, request_cw_odd, request_pe_even, request_pe_odd,
    input  data_cw_even, data_cw_odd, data_pe_even, data_pe_odd,
    input  cwro,
    output grant_cw_even, grant_cw_odd, grant_pe_even, grant_pe_odd,
    output cwso, cwdo
  );

  modport master (
    output polarity,
    output request_cw_even, request_cw_odd, request_pe_even, request_pe_odd,
    output data_cw_even, data_cw_odd, data_pe_even, data_pe_odd,
    output cwro,
    input  grant_cw_even, grant_cw_odd, grant_pe_even, grant_pe_odd,
    input  cwso, cwdo
  );
endinterface

// File: rtl/cw_output.sv
// ---------------------------------------------------------------------------
// cw_output
// Clockwise output stage of the ring router. Each virtual channel (even/odd)
// owns a one-packet buffer. In its own phase a VC arbitrates between the CW
// input stage (pass-through) and the PE injection stage, stores the winner
// with the hop field [55:48] shifted right by one, and in the opposite phase
// launches it onto the CW link so it lands in the matching downstream VC.
//
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous, active-high reset
//   bus  : cw_output_if.slave -- phase, requests/data, combinational grants,
//          registered link strobe cwso / data cwdo, downstream ready cwro
//
// Build option:
//   CW_OUTPUT_RR_ARB_EN defined   -> per-VC round-robin between cw and pe
//   CW_OUTPUT_RR_ARB_EN undefined -> fixed priority, cw over pe
// ---------------------------------------------------------------------------
module cw_output #(
  parameter int DATA_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  cw_output_if.slave  bus
);

  localparam int HOP_LSB = 48;
  localparam int HOP_MSB = 55;

  // Hop field is decremented by a logical right shift; everything else
  // passes through untouched.
  function automatic logic [DATA_WIDTH-1:0] hop_update(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r                  = d;
    r[HOP_MSB:HOP_LSB] = {1'b0, d[HOP_MSB:HOP_LSB+1]};
    return r;
  endfunction

  logic                  full_even;
  logic                  full_odd;
  logic [DATA_WIDTH-1:0] buf_even;
  logic [DATA_WIDTH-1:0] buf_odd;

  logic                  open_even;
  logic                  open_odd;
  logic                  gnt_cw_even;
  logic                  gnt_cw_odd;
  logic                  gnt_pe_even;
  logic                  gnt_pe_odd;
  logic                  wr_even;
  logic                  wr_odd;
  logic                  launch_even;
  logic                  launch_odd;

  // A VC may accept a packet only in its own phase, when empty and out of
  // reset (grants are forced low while rst is high).
  assign open_even = ~rst & ~bus.polarity & ~full_even;
  assign open_odd  = ~rst &  bus.polarity & ~full_odd;

`ifdef CW_OUTPUT_RR_ARB_EN
  // 1 = pe has priority on the next contended cycle, 0 = cw.
  logic prio_even;
  logic prio_odd;

  assign gnt_cw_even = open_even & bus.request_cw_even & ~(bus.request_pe_even & prio_even);
  assign gnt_pe_even = open_even & bus.request_pe_even & ~gnt_cw_even;
  assign gnt_cw_odd  = open_odd  & bus.request_cw_odd  & ~(bus.request_pe_odd  & prio_odd);
  assign gnt_pe_odd  = open_odd  & bus.request_pe_odd  & ~gnt_cw_odd;

  // After every grant the priority moves to the requester that lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_even <= 1'b0;
      prio_odd  <= 1'b0;
    end else begin
      if (gnt_cw_even)      prio_even <= 1'b1;
      else if (gnt_pe_even) prio_even <= 1'b0;
      if (gnt_cw_odd)       prio_odd  <= 1'b1;
      else if (gnt_pe_odd)  prio_odd  <= 1'b0;
    end
  end
`else
  assign gnt_cw_even = open_even & bus.request_cw_even;
  assign gnt_pe_even = open_even & bus.request_pe_even & ~bus.request_cw_even;
  assign gnt_cw_odd  = open_odd  & bus.request_cw_odd;
  assign gnt_pe_odd  = open_odd  & bus.request_pe_odd  & ~bus.request_cw_odd;
`endif

  assign bus.grant_cw_even = gnt_cw_even;
  assign bus.grant_pe_even = gnt_pe_even;
  assign bus.grant_cw_odd  = gnt_cw_odd;
  assign bus.grant_pe_odd  = gnt_pe_odd;

  assign wr_even = gnt_cw_even | gnt_pe_even;
  assign wr_odd  = gnt_cw_odd  | gnt_pe_odd;

  // Each VC launches in the phase opposite to its own so it arrives in its
  // own phase downstream; the two launches are therefore mutually exclusive.
  assign launch_even =  bus.polarity & full_even & bus.cwro;
  assign launch_odd  = ~bus.polarity & full_odd  & bus.cwro;

  // ---- stage: VC buffers (data, written on grant) ----
  always_ff @(posedge clk) begin
    if (wr_even) buf_even <= hop_update(gnt_cw_even ? bus.data_cw_even : bus.data_pe_even);
    if (wr_odd)  buf_odd  <= hop_update(gnt_cw_odd  ? bus.data_cw_odd  : bus.data_pe_odd);
  end

  // ---- stage: full flags and link output register ----
  // A write and a launch never hit the same VC in one cycle, so set and
  // clear of a full flag cannot collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_even <= 1'b0;
      full_odd  <= 1'b0;
      bus.cwso  <= 1'b0;
      bus.cwdo  <= '0;
    end else begin
      full_even <= wr_even | (full_even & ~launch_even);
      full_odd  <= wr_odd  | (full_odd  & ~launch_odd);
      bus.cwso  <= launch_even | launch_odd;
      if (launch_even)     bus.cwdo <= buf_even;
      else if (launch_odd) bus.cwdo <= buf_odd;
    end
  end

endmodule

// File: tb/tb_cw_output.sv
module tb_cw_output;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cw_output_if #(.DATA_WIDTH(64)) bus ();

  cw_output #(.DATA_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus variables; req = {pe_odd, pe_even, cw_odd, cw_even}
  logic        pol = 1'b0;
  logic        ry  = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [63:0] dcw [2];
  logic [63:0] dpe [2];

  assign bus.polarity        = pol;
  assign bus.cwro            = ry;
  assign bus.request_cw_even = req[0];
  assign bus.request_cw_odd  = req[1];
  assign bus.request_pe_even = req[2];
  assign bus.request_pe_odd  = req[3];
  assign bus.data_cw_even    = dcw[0];
  assign bus.data_cw_odd     = dcw[1];
  assign bus.data_pe_even    = dpe[0];
  assign bus.data_pe_odd     = dpe[1];

  int total = 0;
  int bad   = 0;

  logic [3:0] got_g;

  // Reference model: one slot per VC, indexed 0=even 1=odd
  logic        m_full   [2];
  logic [63:0] m_buf    [2];
  logic        m_fav_pe [2];
  logic        m_cwso;
  logic [63:0] m_cwdo;
  logic [3:0]  mg;

  function automatic logic [63:0] ref_hop(input logic [63:0] d);
    return (d & ~64'h00FF_0000_0000_0000) | ((d & 64'h00FE_0000_0000_0000) >> 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task model_comb();
    int v;
    mg = 4'b0;
    if (!rst) begin
      v = pol ? 1 : 0;
      if (!m_full[v]) begin
        if (req[v] && !(req[2+v] && m_fav_pe[v])) mg[v] = 1'b1;
        else if (req[2+v])                         mg[2+v] = 1'b1;
      end
    end
  endtask

  task model_seq();
    int lv;
    int v;
    if (rst) begin
      m_full[0] = 0; m_full[1] = 0;
      m_fav_pe[0] = 0; m_fav_pe[1] = 0;
      m_cwso = 0; m_cwdo = 64'h0;
    end else begin
      lv = pol ? 0 : 1;
      if (m_full[lv] && ry) begin
        m_cwso = 1; m_cwdo = m_buf[lv]; m_full[lv] = 0;
      end else begin
        m_cwso = 0;
      end
      v = pol ? 1 : 0;
      if (mg[v]) begin
        m_buf[v] = ref_hop(dcw[v]); m_full[v] = 1;
`ifdef CW_OUTPUT_RR_ARB_EN
        m_fav_pe[v] = 1;
`endif
      end else if (mg[2+v]) begin
        m_buf[v] = ref_hop(dpe[v]); m_full[v] = 1;
        m_fav_pe[v] = 0;
      end
    end
  endtask

  // One clock: grants sampled mid-cycle, registered outputs 1 time unit after the edge.
  task automatic tick();
    @(negedge clk);
    model_comb();
    got_g = {bus.grant_pe_odd, bus.grant_pe_even, bus.grant_cw_odd, bus.grant_cw_even};
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic set_data(input logic [63:0] d);
    dcw[0] = d; dcw[1] = d;
    dpe[0] = d + 64'd1; dpe[1] = d + 64'd1;
  endtask

  typedef struct packed {
    logic        pol;
    logic [3:0]  req;
    logic        ry;
    logic [63:0] d;
    logic [3:0]  eg;
    logic        eso;
    logic [63:0] edo;
  } vec_t;

  vec_t tbl [10];
  logic [3:0]  exp_g;
  logic [63:0] d6;

  initial begin
    tbl[0] = '{1'b0, 4'b0001, 1'b1, 64'h1104_2233_4455_6670, 4'b0001, 1'b0, 64'h0};
    tbl[1] = '{1'b1, 4'b0000, 1'b1, 64'h0,                   4'b0000, 1'b1, 64'h1102_2233_4455_6670};
    tbl[2] = '{1'b0, 4'b1000, 1'b1, 64'h22F0_0000_0000_0010, 4'b0000, 1'b0, 64'h1102_2233_4455_6670};
    tbl[3] = '{1'b1, 4'b1000, 1'b1, 64'h22F0_0000_0000_0010, 4'b1000, 1'b0, 64'h1102_2233_4455_6670};
    tbl[4] = '{1'b0, 4'b0000, 1'b1, 64'h0,                   4'b0000, 1'b1, 64'h2278_0000_0000_0011};
    tbl[5] = '{1'b1, 4'b0010, 1'b1, 64'h3380_0000_0000_0020, 4'b0010, 1'b0, 64'h2278_0000_0000_0011};
    tbl[6] = '{1'b0, 4'b0001, 1'b1, 64'h4402_0000_0000_0040, 4'b0001, 1'b1, 64'h3340_0000_0000_0020};
    tbl[7] = '{1'b1, 4'b0010, 1'b1, 64'h5501_0000_0000_0050, 4'b0010, 1'b1, 64'h4401_0000_0000_0040};
    tbl[8] = '{1'b0, 4'b0000, 1'b1, 64'h0,                   4'b0000, 1'b1, 64'h5500_0000_0000_0050};
    tbl[9] = '{1'b1, 4'b0000, 1'b1, 64'h0,                   4'b0000, 1'b0, 64'h5500_0000_0000_0050};

    set_data(64'h0);

    // Reset with all requests high: grants must stay low, outputs cleared.
    rst = 1'b1; req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      pol = i[0];
      tick();
      chk("reset_grants", {60'h0, got_g}, 64'h0);
      chk("reset_cwso", {63'h0, bus.cwso}, 64'h0);
      chk("reset_cwdo", bus.cwdo, 64'h0);
    end
    rst = 1'b0; req = 4'b0;

    // Single packet, phase check, interleave.
    for (int i = 0; i < 10; i++) begin
      pol = tbl[i].pol; req = tbl[i].req; ry = tbl[i].ry; set_data(tbl[i].d);
      tick();
      chk($sformatf("vec%0d_grant", i), {60'h0, got_g}, {60'h0, tbl[i].eg});
      chk($sformatf("vec%0d_cwso", i), {63'h0, bus.cwso}, {63'h0, tbl[i].eso});
      chk($sformatf("vec%0d_cwdo", i), bus.cwdo, tbl[i].edo);
    end

    // Contention on odd VC from a fresh reset.
    rst = 1'b1; req = 4'b0; pol = 1'b0; tick(); rst = 1'b0;
    req = 4'b1010; ry = 1'b1; set_data(64'h7710_0000_0000_0070);
    for (int i = 0; i < 8; i++) begin
      pol = (i % 2 == 0);
      tick();
      if (i % 2 != 0) exp_g = 4'b0000;
`ifdef CW_OUTPUT_RR_ARB_EN
      else exp_g = ((i / 2) % 2 == 0) ? 4'b0010 : 4'b1000;
`else
      else exp_g = 4'b0010;
`endif
      chk($sformatf("contend%0d_grant", i), {60'h0, got_g}, {60'h0, exp_g});
    end
    req = 4'b0;
    pol = 1'b1; tick();
    pol = 1'b0; tick();

    // Backpressure on even VC.
    d6 = 64'h6610_AAAA_BBBB_CC00;
    pol = 1'b0; req = 4'b0001; ry = 1'b1; set_data(d6);
    tick();
    chk("bp_fill_grant", {60'h0, got_g}, 64'h1);
    ry = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pol = (i % 2 == 0);
      tick();
      chk($sformatf("bp%0d_grant", i), {60'h0, got_g}, 64'h0);
      chk($sformatf("bp%0d_cwso", i), {63'h0, bus.cwso}, 64'h0);
    end
    pol = 1'b1; ry = 1'b1;
    tick();
    chk("bp_release_cwso", {63'h0, bus.cwso}, 64'h1);
    chk("bp_release_cwdo", bus.cwdo, 64'h6608_AAAA_BBBB_CC00);
    pol = 1'b0;
    tick();
    chk("bp_refill_grant", {60'h0, got_g}, 64'h1);

    // Reset with both buffers full.
    pol = 1'b1; req = 4'b0010; ry = 1'b0;
    tick();
    chk("rstmid_odd_grant", {60'h0, got_g}, 64'h2);
    rst = 1'b1; pol = 1'b0; ry = 1'b1; req = 4'b0011;
    tick();
    chk("rstmid_grants", {60'h0, got_g}, 64'h0);
    chk("rstmid_cwso", {63'h0, bus.cwso}, 64'h0);
    chk("rstmid_cwdo", bus.cwdo, 64'h0);
    rst = 1'b0; req = 4'b0;
    for (int i = 0; i < 4; i++) begin
      pol = (i % 2 == 0);
      tick();
      chk($sformatf("rstmid_idle%0d_cwso", i), {63'h0, bus.cwso}, 64'h0);
    end
    pol = 1'b0; req = 4'b0001; set_data(64'h0920_0000_0000_0001);
    tick();
    chk("rstmid_regrant", {60'h0, got_g}, 64'h1);
    pol = 1'b1; req = 4'b0;
    tick();
    chk("rstmid_send_cwdo", bus.cwdo, 64'h0910_0000_0000_0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      pol = $urandom_range(0, 1);
      req = 4'($urandom_range(0, 15));
      ry  = ($urandom_range(0, 3) != 0);
      dcw[0] = {$urandom, $urandom}; dcw[1] = {$urandom, $urandom};
      dpe[0] = {$urandom, $urandom}; dpe[1] = {$urandom, $urandom};
      tick();
      chk("rand_grant", {60'h0, got_g}, {60'h0, mg});
      chk("rand_cwso", {63'h0, bus.cwso}, {63'h0, m_cwso});
      chk("rand_cwdo", bus.cwdo, m_cwdo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
